// File: rtl/pkg_uc.sv
// pkg_uc: shared widths, ALU opcodes and the decode-to-execute bundle.
package pkg_uc;
    localparam int DATA_W  = 16;
    localparam int ADRS_W  = 2;
    localparam int SHAMT_W = $clog2(DATA_W);

    typedef logic [ADRS_W-1:0] t_RFadrs;
    typedef logic [DATA_W-1:0] t_data;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SHL  = 3'd5,
        ALU_SHR  = 3'd6,
        ALU_PASS = 3'd7
    } t_ALUop;

    typedef struct packed {
        logic    ALUsrc1;
        logic    ALUsrc2;
        t_ALUop  ALUop;
        logic    wr_en;
        logic    dataoutv;
        t_RFadrs src1;
        t_RFadrs src2;
        t_data   dat1;
        t_data   dat2;
        t_data   imm;
        t_RFadrs dst;
    } t_IDtoEX;
endpackage

// File: rtl/execute_stage_alu.sv
// alu: combinational datapath of the execute stage.
module alu
    import pkg_uc::*;
(
    input  t_ALUop op,
    input  t_data  a,
    input  t_data  b,
    output t_data  res,
    output logic   zero
);
    always_comb begin
        res = b;
        case (op)
            ALU_ADD: res = a + b;
            ALU_SUB: res = a - b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_SHL: res = a << b[SHAMT_W-1:0];
            ALU_SHR: res = a >> b[SHAMT_W-1:0];
            default: res = b;
        endcase
        zero = (res == '0);
    end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: x0->x1 capture, ALU with x2/x3 forwarding, x2 result/write-back registers.
module execute_stage
    import pkg_uc::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              internal_reset,
    input  logic              stalled,
    input  logic              ALUsrc1x0,
    input  logic              ALUsrc2x0,
    input  logic [2:0]        ALUopx0,
    input  logic              wr_enx0,
    input  logic              dataoutvx0,
    input  logic [ADRS_W-1:0] src1x0,
    input  logic [ADRS_W-1:0] src2x0,
    input  logic [DATA_W-1:0] dat1x0,
    input  logic [DATA_W-1:0] dat2x0,
    input  logic [DATA_W-1:0] immx0,
    input  logic [ADRS_W-1:0] dstx0,
    output logic [ADRS_W-1:0] dstx2,
    output logic [DATA_W-1:0] dataoutx2,
    output logic              wr_enx2,
    output logic              dataoutvx2,
    output logic              zerox2
);
    t_IDtoEX x1;
    t_RFadrs dstx3;
    t_data   datx3;
    logic    wr_enx3;
    t_data   fwd1, fwd2, a, b, res;
    logic    zero;

    // x2 is the younger producer, so its match must win over x3
    always_comb begin
        fwd1 = (wr_enx2 && dstx2 == x1.src1) ? dataoutx2 :
               (wr_enx3 && dstx3 == x1.src1) ? datx3 : x1.dat1;
        fwd2 = (wr_enx2 && dstx2 == x1.src2) ? dataoutx2 :
               (wr_enx3 && dstx3 == x1.src2) ? datx3 : x1.dat2;
        a    = x1.ALUsrc1 ? '0 : fwd1;
        b    = x1.ALUsrc2 ? x1.imm : fwd2;
    end

    alu u_alu (
        .op  (x1.ALUop),
        .a   (a),
        .b   (b),
        .res (res),
        .zero(zero)
    );

    always_ff @(posedge clock) begin
        if (reset || internal_reset) begin
            x1         <= '0;
            dstx2      <= '0;
            dataoutx2  <= '0;
            wr_enx2    <= 1'b0;
            dataoutvx2 <= 1'b0;
            zerox2     <= 1'b0;
            dstx3      <= '0;
            datx3      <= '0;
            wr_enx3    <= 1'b0;
        end else begin
            x1 <= '{ALUsrc1: ALUsrc1x0, ALUsrc2: ALUsrc2x0, ALUop: t_ALUop'(ALUopx0),
                    wr_en: wr_enx0 && !stalled, dataoutv: dataoutvx0 && !stalled,
                    src1: src1x0, src2: src2x0, dat1: dat1x0, dat2: dat2x0,
                    imm: immx0, dst: dstx0};
            dstx2      <= x1.dst;
            dataoutx2  <= res;
            wr_enx2    <= x1.wr_en;
            dataoutvx2 <= x1.dataoutv;
            zerox2     <= zero;
            dstx3      <= dstx2;
            datx3      <= dataoutx2;
            wr_enx3    <= wr_enx2;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: random + directed stimulus against a sequential register-file model.
module tb_execute_stage;
    import pkg_uc::*;
    localparam int NC = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, irst, stl, s1x0, s2x0, wx0, dvx0;
    logic [2:0]  opx0;
    logic [1:0]  src1x0, src2x0, dstx0, dstx2;
    logic [15:0] dat1x0, dat2x0, immx0, doutx2;
    logic        wx2, dvx2, zx2;

    int cyc = 0, tests = 0, fails = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // phys: the register file as the consumer's x0 read sees it (writes land 3 cycles after issue)
    logic [15:0] phys [4];
    bit          pw_v [NC];
    logic [1:0]  pw_a [NC];
    logic [15:0] pw_d [NC];
    bit          e_w [NC], e_dv [NC], e_full [NC];
    logic [1:0]  e_dst [NC];
    logic [15:0] e_dat [NC];
    bit          l_on [NC], l_w [NC], l_z [NC];
    logic [1:0]  l_dst [NC];
    logic [15:0] l_dat [NC];
    bit rq, fq, sq;

    execute_stage dut (
        .clock(clk), .reset(rst), .internal_reset(irst), .stalled(stl),
        .ALUsrc1x0(s1x0), .ALUsrc2x0(s2x0), .ALUopx0(opx0), .wr_enx0(wx0),
        .dataoutvx0(dvx0), .src1x0(src1x0), .src2x0(src2x0), .dat1x0(dat1x0),
        .dat2x0(dat2x0), .immx0(immx0), .dstx0(dstx0), .dstx2(dstx2),
        .dataoutx2(doutx2), .wr_enx2(wx2), .dataoutvx2(dvx2), .zerox2(zx2)
    );

    function automatic logic [15:0] model_alu(input int op, input logic [15:0] a, input logic [15:0] b);
        int sh;
        sh = int'(b) % 16;
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << sh;
            6: return a >> sh;
            default: return b;
        endcase
    endfunction

    task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, got, exp);
        end
    endtask

    task automatic lit(input int c, input logic [15:0] d, input bit w, input bit z, input logic [1:0] dst);
        l_on[c] = 1; l_dat[c] = d; l_w[c] = w; l_z[c] = z; l_dst[c] = dst;
    endtask

    // drive one x0 slot for the current cycle, record what must appear two cycles later, advance
    task automatic ins(input int op, input bit s1, input bit s2, input int r1, input int r2,
                       input int d, input logic [15:0] imm, input bit w, input bit dv);
        logic [15:0] arch [4];
        logic [15:0] res;
        int c;
        c = cyc;
        if (c >= 3 && pw_v[c-3]) phys[pw_a[c-3]] = pw_d[c-3];
        arch = phys;
        for (int k = c - 2; k < c; k++)
            if (k >= 0 && pw_v[k]) arch[pw_a[k]] = pw_d[k];
        rst = rq; irst = fq; stl = sq;
        s1x0 = s1; s2x0 = s2; opx0 = 3'(op); wx0 = w; dvx0 = dv;
        src1x0 = 2'(r1); src2x0 = 2'(r2); dstx0 = 2'(d); immx0 = imm;
        dat1x0 = phys[r1]; dat2x0 = phys[r2];
        res = model_alu(op, s1 ? 16'h0 : arch[r1], s2 ? imm : arch[r2]);
        if (rq || fq) begin
            pw_v[c] = 0;
            if (c >= 1) pw_v[c-1] = 0;
            e_full[c+1] = 1; e_w[c+1] = 0; e_dv[c+1] = 0;
            e_w[c+2] = 0; e_dv[c+2] = 0;
        end else begin
            pw_v[c] = w && !sq; pw_a[c] = 2'(d); pw_d[c] = res;
            e_w[c+2] = w && !sq; e_dv[c+2] = dv && !sq;
            e_dst[c+2] = 2'(d); e_dat[c+2] = res; e_full[c+2] = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bub();
        ins(0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("wr_enx2", 16'(wx2), 16'(e_w[cyc]));
            chk("dataoutvx2", 16'(dvx2), 16'(e_dv[cyc]));
            if (e_full[cyc]) begin
                chk("rst_dstx2", 16'(dstx2), 16'h0);
                chk("rst_dataoutx2", doutx2, 16'h0);
                chk("rst_zerox2", 16'(zx2), 16'h0);
            end else if (e_w[cyc] || e_dv[cyc]) begin
                chk("dstx2", 16'(dstx2), 16'(e_dst[cyc]));
                chk("dataoutx2", doutx2, e_dat[cyc]);
                chk("zerox2", 16'(zx2), 16'(e_dat[cyc] == 16'h0));
            end
            if (l_on[cyc]) begin
                chk("lit_wr_en", 16'(wx2), 16'(l_w[cyc]));
                if (l_w[cyc]) begin
                    chk("lit_data", doutx2, l_dat[cyc]);
                    chk("lit_zero", 16'(zx2), 16'(l_z[cyc]));
                    chk("lit_dst", 16'(dstx2), 16'(l_dst[cyc]));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) phys[i] = 16'h0;
        rq = 1; fq = 0; sq = 0;
        ins(0, 0, 1, 0, 0, 1, 16'h1, 1, 1);
        ins(0, 0, 1, 0, 0, 1, 16'h1, 1, 1);
        rq = 0;
        // ADD wrap: r0 = FFFF, let it land, then r1 = r0 + 2
        ins(7, 0, 1, 0, 0, 0, 16'hFFFF, 1, 0);
        bub(); bub();
        lit(cyc + 2, 16'h0001, 1, 0, 2'd1);
        ins(0, 0, 1, 0, 0, 1, 16'h0002, 1, 1);
        // back-to-back RAW through x2
        ins(7, 0, 1, 0, 0, 1, 16'h0005, 1, 0);
        lit(cyc + 2, 16'h000A, 1, 0, 2'd2);
        ins(0, 0, 0, 1, 1, 2, 16'h0, 1, 0);
        // distance-2 RAW through x3, then x2 priority over x3
        ins(7, 0, 1, 0, 0, 3, 16'h0007, 1, 0);
        bub();
        lit(cyc + 2, 16'h0008, 1, 0, 2'd0);
        ins(0, 0, 1, 3, 0, 0, 16'h0001, 1, 0);
        ins(7, 0, 1, 0, 0, 3, 16'h0007, 1, 0);
        ins(7, 0, 1, 0, 0, 3, 16'h0009, 1, 0);
        lit(cyc + 2, 16'h000A, 1, 0, 2'd0);
        ins(0, 0, 1, 3, 0, 0, 16'h0001, 1, 0);
        // stall bubble
        sq = 1;
        lit(cyc + 2, 16'h0, 0, 0, 2'd0);
        ins(7, 0, 1, 0, 0, 2, 16'h0003, 1, 1);
        sq = 0;
        // flush with two instructions in flight
        ins(7, 0, 1, 0, 0, 1, 16'h0011, 1, 1);
        fq = 1;
        lit(cyc + 1, 16'h0, 0, 0, 2'd0);
        lit(cyc + 2, 16'h0, 0, 0, 2'd0);
        ins(7, 0, 1, 0, 0, 2, 16'h0022, 1, 1);
        fq = 0;
        bub();
        // ops sweep
        lit(cyc + 2, 16'hFFFF, 1, 0, 2'd0);
        ins(1, 1, 1, 0, 0, 0, 16'h0001, 1, 1);
        ins(7, 0, 1, 0, 0, 1, 16'h0001, 1, 0);
        lit(cyc + 2, 16'h8000, 1, 0, 2'd2);
        ins(5, 0, 1, 1, 0, 2, 16'd15, 1, 1);
        ins(7, 0, 1, 0, 0, 1, 16'h8000, 1, 0);
        lit(cyc + 2, 16'h8000, 1, 0, 2'd2);
        ins(6, 0, 1, 1, 0, 2, 16'd16, 1, 1);
        lit(cyc + 2, 16'h0000, 1, 1, 2'd0);
        ins(4, 0, 0, 1, 1, 0, 16'h0, 1, 1);
        // random traffic with stalls, flushes and resets
        repeat (1500) begin
            rq = ($urandom % 60) == 0;
            fq = !rq && ($urandom % 50) == 0;
            sq = ($urandom % 4) == 0;
            ins(int'($urandom % 8), bit'($urandom % 4 == 0), bit'($urandom % 2),
                int'($urandom % 4), int'($urandom % 4), int'($urandom % 4),
                ($urandom % 3 == 0) ? 16'($urandom % 20) : 16'($urandom),
                bit'($urandom % 4 != 0), bit'($urandom % 2));
        end
        rq = 0; fq = 0; sq = 0;
        repeat (4) bub();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
